// File: rtl/donut_reset_initiator.sv
// -----------------------------------------------------------------------------
// donut_reset_initiator
//
// Donut-side initiator of the action reset handshake. A host trigger (or an
// automatic request after system reset) starts a sequence: donutRstReq is
// pulsed for ReqPulseCycles cycles, then the block waits up to TimeoutCycles+1
// cycles for donutRstDone. A timeout re-issues the request up to MaxRetries
// times before the sequence is reported as failed.
//
// Ports
//   clk           in   single clock
//   rst           in   asynchronous, active-high reset
//   rstTrig       in   single-cycle reset request from host control
//   donutRstReq   out  reset request to the action reset handler
//   donutRstDone  in   reset-done level from the action reset handler
//   rstBusy       out  high while a sequence is in progress
//   rstComplete   out  one-cycle pulse on successful completion
//   rstFailed     out  sticky failure flag, cleared when a new sequence starts
//   retryCount    out  retries used in the current/last sequence
// -----------------------------------------------------------------------------
module donut_reset_initiator #(
  parameter int ReqPulseCycles     = 4,
  parameter int ReqCounterSize     = 3,
  parameter int TimeoutCycles      = 1023,
  parameter int TimeoutCounterSize = 10,
  parameter int MaxRetries         = 2,
  parameter int StartupReset       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rstTrig,
  output logic       donutRstReq,
  input  logic       donutRstDone,
  output logic       rstBusy,
  output logic       rstComplete,
  output logic       rstFailed,
  output logic [3:0] retryCount
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAssert = 2'd1;
  localparam logic [1:0] StWait   = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

  localparam logic [ReqCounterSize-1:0]     PulseLoad   = ReqCounterSize'(ReqPulseCycles - 1);
  localparam logic [ReqCounterSize-1:0]     PulseOne    = ReqCounterSize'(1);
  localparam logic [ReqCounterSize-1:0]     PulseZero   = ReqCounterSize'(0);
  localparam logic [TimeoutCounterSize-1:0] TimeoutLoad = TimeoutCounterSize'(TimeoutCycles);
  localparam logic [TimeoutCounterSize-1:0] TimeoutOne  = TimeoutCounterSize'(1);
  localparam logic [TimeoutCounterSize-1:0] TimeoutZero = TimeoutCounterSize'(0);
  localparam logic [3:0]                    RetryLimit  = 4'(MaxRetries);
  localparam logic                          PendingInit = (StartupReset != 0) ? 1'b1 : 1'b0;

  logic [1:0]                    state_r;
  logic [1:0]                    nextState_s;
  logic [ReqCounterSize-1:0]     pulseCnt_r;
  logic [ReqCounterSize-1:0]     pulseCnt_s;
  logic [TimeoutCounterSize-1:0] timeoutCnt_r;
  logic [TimeoutCounterSize-1:0] timeoutCnt_s;
  logic [3:0]                    retryCount_s;
  logic                          failed_s;
  logic                          pending_r;
  logic                          pending_s;

  // Next-state, counter, retry, failure and pending-trigger logic.
  always_comb begin
    nextState_s  = state_r;
    pulseCnt_s   = pulseCnt_r;
    timeoutCnt_s = timeoutCnt_r;
    retryCount_s = retryCount;
    failed_s     = rstFailed;
    pending_s    = pending_r;

    case (state_r)
      StIdle: begin
        // A fresh trigger and a queued one are serviced identically.
        if (rstTrig || pending_r) begin
          nextState_s  = StAssert;
          pulseCnt_s   = PulseLoad;
          retryCount_s = 4'd0;
          failed_s     = 1'b0;
          pending_s    = 1'b0;
        end else begin
          nextState_s  = StIdle;
        end
      end

      StAssert: begin
        // Triggers arriving mid-sequence merge into a single pending request.
        pending_s = pending_r | rstTrig;
        if (pulseCnt_r != PulseZero) begin
          pulseCnt_s   = pulseCnt_r - PulseOne;
        end else begin
          nextState_s  = StWait;
          timeoutCnt_s = TimeoutLoad;
        end
      end

      StWait: begin
        pending_s = pending_r | rstTrig;
        // Done wins over a timeout that expires on the same edge.
        if (donutRstDone) begin
          nextState_s  = StDone;
        end else if (timeoutCnt_r != TimeoutZero) begin
          timeoutCnt_s = timeoutCnt_r - TimeoutOne;
        end else if (retryCount < RetryLimit) begin
          retryCount_s = retryCount + 4'd1;
          nextState_s  = StAssert;
          pulseCnt_s   = PulseLoad;
        end else begin
          failed_s     = 1'b1;
          nextState_s  = StIdle;
        end
      end

      StDone: begin
        pending_s   = pending_r | rstTrig;
        nextState_s = StIdle;
      end

      default: begin
        nextState_s = StIdle;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= StIdle;
      pulseCnt_r   <= PulseZero;
      timeoutCnt_r <= TimeoutZero;
      pending_r    <= PendingInit;
      retryCount   <= 4'd0;
      rstFailed    <= 1'b0;
      donutRstReq  <= 1'b0;
      rstBusy      <= 1'b0;
      rstComplete  <= 1'b0;
    end else begin
      state_r      <= nextState_s;
      pulseCnt_r   <= pulseCnt_s;
      timeoutCnt_r <= timeoutCnt_s;
      pending_r    <= pending_s;
      retryCount   <= retryCount_s;
      rstFailed    <= failed_s;
      donutRstReq  <= (nextState_s == StAssert);
      rstBusy      <= (nextState_s == StAssert) || (nextState_s == StWait);
      rstComplete  <= (nextState_s == StDone);
    end
  end

endmodule
